// File: rtl/uart_frame_arbiter.sv
// Purpose: round-robin sharing of one Rs232_Controller between NUM_REQ frame requesters.
// Latency: req seen in IDLE at cycle k -> ctl_start at k+2; ctl_done at cycle d -> ack/rx_valid at d+1; >= 5 cycles per grant.
// Backpressure: req is a level held until ack; requests queue implicitly and are arbitrated only in IDLE, one grant at a time.
//
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   req / req_data         per-requester request level and concatenated frames (requester i at [i*N*n +: N*n])
//   ack / rx_data/rx_valid one-cycle completion pulse to the owner plus the frame returned by the controller
//   busy / owner           high outside IDLE / current or last granted requester
//   ctl_start/ctl_data_in  start pulse and frame towards the controller
//   ctl_done/ctl_data_out  completion flag and result frame from the controller
//   timeout_err            watchdog expiry pulse
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the WAIT watchdog of TIMEOUT_CYC cycles;
// without it WAIT blocks until ctl_done and timeout_err is tied low.
module uart_frame_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int N           = 8,
  parameter int n           = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*N*n-1:0]       req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         ctl_start,
  output logic [N*n-1:0]               ctl_data_in,
  input  logic                         ctl_done,
  input  logic [N*n-1:0]               ctl_data_out,
  output logic [N*n-1:0]               rx_data,
  output logic                         rx_valid,
  output logic                         timeout_err
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int FW    = N * n;

  if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_frame_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [OWN_W-1:0] last_grant;
  logic [OWN_W-1:0] pick;
  logic [OWN_W-1:0] idx;
  logic             pick_vld;
  logic             expire;
  logic [FW-1:0]    frame_arr [NUM_REQ];

  // Unpacked view of the concatenated frames so the owner can index it directly.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      frame_arr[i] = req_data[i*FW +: FW];
    end
  end

  // Round-robin pick: first set req bit scanning upward from last_grant+1 with
  // wrap modulo NUM_REQ, so non-power-of-2 NUM_REQ never yields an out-of-range index.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = OWN_W'((int'(last_grant) + i) % NUM_REQ);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (ctl_done || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the next-state decode so that busy, ctl_start,
  // ack and rx_valid line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= OWN_W'(NUM_REQ - 1);
      owner       <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      ctl_start   <= 1'b0;
      ctl_data_in <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      ctl_start <= (state_nxt == START);
      ack       <= '0;
      rx_valid  <= 1'b0;
      case (state)
        IDLE: if (pick_vld) owner <= pick;
        LOAD: ctl_data_in <= frame_arr[owner];
        WAIT: begin
          if (state_nxt == DONE) begin
            ack <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
            // A done coinciding with watchdog expiry counts as a normal completion.
            if (ctl_done) begin
              rx_data  <= ctl_data_out;
              rx_valid <= 1'b1;
            end
          end
        end
        DONE:    last_grant <= owner;
        default: ;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt counts completed WAIT cycles; expiry fires on the cycle that would
  // make it reach TIMEOUT_CYC, so WAIT lasts exactly TIMEOUT_CYC cycles.
  assign expire = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= expire && !ctl_done;
      if (state == START) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Purpose: scoreboard bench for uart_frame_arbiter with a behavioural controller and round-robin reference model.
// Latency: checks ctl_start at req+2 from idle, ack/rx_valid at ctl_done+1 (or start+TIMEOUT+1 on watchdog expiry).
// Backpressure: requesters hold req until their ack (optionally dropping early or holding on), controller answers after a random delay.
module tb_uart_frame_arbiter;

  localparam int NR = 4;
  localparam int FW = 64;
  localparam int TO = 16;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int T1_DLY  = 12;
  localparam int DLY_MAX = 12;
`else
  localparam int T1_DLY  = 20;
  localparam int DLY_MAX = 20;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*FW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic              busy;
  logic [1:0]        owner;
  logic              ctl_start;
  logic [FW-1:0]     ctl_data_in;
  logic              ctl_done;
  logic [FW-1:0]     ctl_data_out;
  logic [FW-1:0]     rx_data;
  logic              rx_valid;
  logic              timeout_err;

  uart_frame_arbiter #(
    .NUM_REQ     (NR),
    .N           (8),
    .n           (8),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .busy         (busy),
    .owner        (owner),
    .ctl_start    (ctl_start),
    .ctl_data_in  (ctl_data_in),
    .ctl_done     (ctl_done),
    .ctl_data_out (ctl_data_out),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  typedef struct { int own; logic [FW-1:0] frame; } start_t;
  typedef struct { int own; logic [FW-1:0] rx; bit to; } ack_t;

  start_t sq[$];
  ack_t   aq[$];
  int     order_q[$];

  // Reference model state: last served requester and last rx frame delivered.
  int            m_last = NR - 1;
  logic [FW-1:0] m_rx   = '0;
  logic [FW-1:0] frm [NR];

  // Controller model knobs.
  bit            spurious_en = 1'b0;
  bit            never_done  = 1'b0;
  int            dly_min     = 1;
  int            dly_max     = DLY_MAX;
  logic [FW-1:0] ctl_mask    = '0;
  int            last_done_cyc  = -100;
  int            last_start_cyc = -100;
  int            round_req_cyc  = 0;

  // Expected grant sequence from the round-robin rule applied to the request set.
  task automatic predict(input logic [NR-1:0] m, input int grants, input bit hold, input bit to);
    logic [NR-1:0] p;
    int            pick;
    int            cand;
    logic [FW-1:0] rx;
    p = m;
    for (int g = 0; g < grants; g++) begin
      pick = -1;
      for (int i = 1; i <= NR; i++) begin
        cand = (m_last + i) % NR;
        if (pick < 0 && p[cand]) pick = cand;
      end
      if (pick < 0) break;
      m_last = pick;
      if (!hold) p[pick] = 1'b0;
      rx   = to ? m_rx : (frm[pick] ^ ctl_mask);
      m_rx = rx;
      sq.push_back('{pick, frm[pick]});
      aq.push_back('{pick, rx, to});
      order_q.push_back(pick);
    end
  endtask

  task automatic rand_frames();
    for (int i = 0; i < NR; i++) frm[i] = {$urandom, $urandom};
  endtask

  task automatic pack_frames();
    for (int i = 0; i < NR; i++) req_data[i*FW +: FW] = frm[i];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},         ack, '0);
    check({tag, "_busy"},        busy, '0);
    check({tag, "_owner"},       owner, '0);
    check({tag, "_ctl_start"},   ctl_start, '0);
    check({tag, "_ctl_data_in"}, ctl_data_in, '0);
    check({tag, "_rx_data"},     rx_data, '0);
    check({tag, "_rx_valid"},    rx_valid, '0);
    check({tag, "_timeout_err"}, timeout_err, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (3) @(negedge clk);
    sq.delete();
    aq.delete();
    order_q.delete();
    m_last = NR - 1;
    m_rx   = '0;
    reset  = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request set and services acks; called on a negedge with the DUT idle.
  task automatic run_round(input logic [NR-1:0] m, input int grants, input bit hold,
                           input bit early_drop, input bit to);
    int got;
    int budget;
    int own;
    got    = 0;
    budget = 0;
    pack_frames();
    predict(m, grants, hold, to);
    round_req_cyc = cyc;
    req = m;
    while (got < grants && budget < grants * 60) begin
      @(negedge clk);
      budget++;
      if (early_drop && !hold && ctl_start && order_q.size() > 0) req[order_q[0]] = 1'b0;
      if (ack != '0) begin
        got++;
        own = (order_q.size() > 0) ? order_q.pop_front() : 0;
        if (!hold) req[own] = 1'b0;
        if (got == grants) begin
          req = '0;
        end else if (hold) begin
          @(negedge clk);
          check("busy_idle_gap", busy, 1'b0);
          @(negedge clk);
          check("busy_regrant", busy, 1'b1);
          budget += 2;
        end
      end
    end
    if (got < grants) begin
      fail_now("round_ack_timeout");
      do_reset();
    end else begin
      repeat (2) @(negedge clk);
      check("idle_after_round", busy, 1'b0);
    end
  endtask

  // Controller model: answers each start after a delay, optionally with stray done pulses.
  initial begin : controller
    bit            pend;
    int            cnt;
    logic [FW-1:0] seen;
    pend         = 1'b0;
    cnt          = 0;
    seen         = '0;
    ctl_done     = 1'b0;
    ctl_data_out = '0;
    forever begin
      @(negedge clk);
      ctl_done     = 1'b0;
      ctl_data_out = {$urandom, $urandom};
      if (reset) begin
        pend = 1'b0;
      end else if (ctl_start) begin
        pend = 1'b1;
        seen = ctl_data_in;
        cnt  = $urandom_range(dly_max, dly_min);
        if (spurious_en) ctl_done = 1'b1;
      end else if (pend) begin
        cnt--;
        if (cnt == 0 && !never_done) begin
          ctl_done      = 1'b1;
          ctl_data_out  = seen ^ ctl_mask;
          pend          = 1'b0;
          last_done_cyc = cyc;
        end
      end else if (spurious_en) begin
        ctl_done = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a start or a completion.
  initial begin : monitor
    start_t s;
    ack_t   a;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) continue;
      if (ctl_start) begin
        last_start_cyc = cyc;
        if (sq.size() == 0) begin
          fail_now("unexpected_ctl_start");
        end else begin
          s = sq.pop_front();
          check("grant_owner", owner, s.own);
          check("ctl_data_in", ctl_data_in, s.frame);
        end
      end
      if (ack != '0 || rx_valid || timeout_err) begin
        if (aq.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          a = aq.pop_front();
          check("ack_vec", ack, 1 << a.own);
          check("rx_valid", rx_valid, !a.to);
          check("timeout_err", timeout_err, a.to);
          check("rx_data", rx_data, a.rx);
          if (a.to) check("timeout_latency", cyc - last_start_cyc, TO + 1);
          else      check("ack_latency", cyc - last_done_cyc, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    fail_now("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : stimulus
    int w;
    int lows;
    logic [NR-1:0] m;
    bit hold;
    int grants;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single request from requester 0, controller echoes the frame.
    dly_min = T1_DLY;
    dly_max = T1_DLY;
    rand_frames();
    frm[0] = 64'h0A0A_AA0A_AA0A_AA0A;
    run_round(4'b0001, 1, 1'b0, 1'b0, 1'b0);
    check("start_latency", last_start_cyc - round_req_cyc, 2);
    check("t1_rx_data", rx_data, 64'h0A0A_AA0A_AA0A_AA0A);
    dly_min = 1;
    dly_max = DLY_MAX;

    // All four held: grant order 0,1,2,3,0 from reset.
    do_reset();
    rand_frames();
    run_round(4'b1111, 5, 1'b1, 1'b0, 1'b0);

    // Requester 1 served, then 1010 -> 3 before 1.
    rand_frames();
    run_round(4'b0010, 1, 1'b0, 1'b0, 1'b0);
    rand_frames();
    run_round(4'b1010, 2, 1'b0, 1'b0, 1'b0);

    // Stray done pulses outside WAIT must not complete the frame.
    spurious_en = 1'b1;
    ctl_mask    = {$urandom, $urandom};
    rand_frames();
    run_round(4'b0110, 2, 1'b0, 1'b1, 1'b0);
    spurious_en = 1'b0;

    // Reset 10 cycles into WAIT: no ack, outputs cleared, requester 0 first afterwards.
    rand_frames();
    run_round(4'b0100, 1, 1'b0, 1'b0, 1'b0);
    never_done = 1'b1;
    rand_frames();
    pack_frames();
    predict(4'b1000, 1, 1'b0, 1'b0);
    req = 4'b1000;
    w = 0;
    while (!ctl_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ctl_start) fail_now("reset_test_no_start");
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("reset_in_wait");
    never_done = 1'b0;
    do_reset();
    rand_frames();
    run_round(4'b1001, 2, 1'b0, 1'b0, 1'b0);

    // Controller never answers.
    never_done = 1'b1;
    rand_frames();
`ifdef UART_ARB_TIMEOUT_EN
    run_round(4'b0001, 1, 1'b0, 1'b0, 1'b1);
    never_done = 1'b0;
    rand_frames();
    run_round(4'b0011, 2, 1'b0, 1'b0, 1'b0);
`else
    pack_frames();
    predict(4'b0001, 1, 1'b0, 1'b0);
    void'(aq.pop_back());
    req  = 4'b0001;
    lows = 0;
    repeat (3) @(negedge clk);
    repeat (60) begin
      @(negedge clk);
      if (!busy) lows++;
    end
    check("hang_busy_low_cycles", lows, 0);
    never_done = 1'b0;
    do_reset();
`endif

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom_range(15, 1));
      hold = ($urandom_range(3, 0) == 0);
      grants = hold ? $urandom_range(6, 2) : $countones(m);
      spurious_en = $urandom_range(1, 0);
      ctl_mask = {$urandom, $urandom};
      rand_frames();
      run_round(m, grants, hold, !hold && ($urandom_range(1, 0) == 1), 1'b0);
    end
    spurious_en = 1'b0;

    repeat (5) @(negedge clk);
    check("start_queue_empty", sq.size(), 0);
    check("ack_queue_empty", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_arbiter.md
Name: uart_frame_arbiter

Overview:
- Shares one Rs232_Controller instance between NUM_REQ requesters that each present a full N×n-bit frame.
- Picks a requester round-robin, loads its frame and pulses the controller start, waits for done, then returns the received frame to the owner with a one-cycle ack.
- Sits between the application-side frame sources and the controller's start/done handshake.

Parameters:
- NUM_REQ, 4: number of requesters; must be 2 or more.
- N, 8: bytes per frame.
- n, 8: bits per byte.
- TIMEOUT_CYC, 65535: watchdog limit in clk cycles, counted in WAIT. Used only with the optional feature.
- Localparam OWN_W = $clog2(NUM_REQ).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester frame request; level, held until matching ack
- req_data  input  NUM_REQ*N*n  concatenated frames; requester i occupies bits [i*N*n +: N*n]
- ack  output  NUM_REQ  one-cycle pulse to the owner when its frame completes
- busy  output  1  high in every state except IDLE
- owner  output  OWN_W  index of the current or last granted requester
- ctl_start  output  1  start pulse to the controller
- ctl_data_in  output  N*n  frame presented to the controller
- ctl_done  input  1  controller completion flag
- ctl_data_out  input  N*n  controller result frame
- rx_data  output  N*n  result latched at completion
- rx_valid  output  1  one-cycle pulse, coincident with ack
- timeout_err  output  1  one-cycle pulse on watchdog expiry; constant 0 without the optional feature

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - ack=0, busy=0, owner=0, ctl_start=0, ctl_data_in=0, rx_data=0, rx_valid=0, timeout_err=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - A reset mid-transaction abandons the frame with no ack.
- All outputs are registered.
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit scanning (last_grant+1) mod NUM_REQ upward with wrap.
  - Register owner, go to LOAD.
  - If req==0, stay in IDLE.
- LOAD:
  - ctl_data_in <= req_data slice[owner]; busy=1.
  - Next state START.
- START:
  - ctl_start=1 for exactly this one cycle.
  - Next state WAIT.
- WAIT:
  - ctl_start=0; ctl_data_in held stable.
  - On ctl_done=1, capture rx_data <= ctl_data_out and go to DONE.
- DONE:
  - ack[owner]=1, rx_valid=1 for one cycle; last_grant <= owner.
  - Next state IDLE.
- Latency:
  - req seen in IDLE at cycle k: ctl_start at k+2.
  - ctl_done sampled at cycle d: ack/rx_valid at d+1.
  - Minimum spacing between two grants is 5 cycles.
- ctl_done asserted outside WAIT is ignored.
- A req drop after grant does not abort the transaction; the ack is still issued.
- Requests arriving while busy wait and are arbitrated only in IDLE.
- Simultaneous requests: only one grant at a time; fairness is strict round-robin.
- A requester that keeps req high after its ack is rearbitrated behind the other active requesters.
- NUM_REQ that is not a power of 2: the wrap uses modulo NUM_REQ, so no out-of-range owner is ever produced.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT_CYC without ctl_done, go to DONE with timeout_err=1 and ack[owner]=1.
  - rx_valid=0 and rx_data keeps its previous value.
  - ctl_done arriving in the same cycle as expiry wins, with normal completion and no error.
- UART_ARB_TIMEOUT_EN undefined:
  - No counter; WAIT blocks until ctl_done.
  - timeout_err is tied to 0.

Test Plan:
- Reset then a single request: req=4'b0001, req_data[63:0]=64'h0A0A_AA0A_AA0A_AA0A, controller model asserts done 20 cycles after start and returns the frame -> ctl_start pulse 2 cycles after req, ctl_data_in equals that frame, ack=4'b0001 and rx_valid one cycle after done, rx_data=64'h0A0A_AA0A_AA0A_AA0A.
- All four requesters held high -> grant order 0,1,2,3,0; each ack is a single pulse; busy low for exactly one IDLE cycle between frames.
- req=4'b1010 after requester 1 was last served -> requester 3 granted first, then 1.
- Reset asserted in WAIT, 10 cycles after start -> all outputs 0 immediately; no ack; after release, requester 0 has priority.
- ctl_done pulsed during LOAD and START -> ignored; state advances to WAIT; completion occurs only on the later done.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, controller never asserts done -> after 16 WAIT cycles, timeout_err=1 and ack[owner]=1, rx_valid=0. Without the macro, the same stimulus leaves busy high indefinitely.
